// File: rtl/input_debouncer_if.sv
// Raw switch inputs and debounced level/edge outputs of the three-channel
// input debouncer. The debouncer sits on the slave side.
interface input_debouncer_if;
  logic       break_raw;
  logic       ignition_raw;
  logic       hidden_sw_raw;
  logic       break_out;
  logic       ignition;
  logic       hidden_sw;
  logic [2:0] rise;
  logic [2:0] fall;

  modport master (
    output break_raw,
    output ignition_raw,
    output hidden_sw_raw,
    input  break_out,
    input  ignition,
    input  hidden_sw,
    input  rise,
    input  fall
  );

  modport slave (
    input  break_raw,
    input  ignition_raw,
    input  hidden_sw_raw,
    output break_out,
    output ignition,
    output hidden_sw,
    output rise,
    output fall
  );
endinterface

// File: rtl/input_debouncer.sv
// Three independent switch debouncers: 2-flop synchronizer, stability counter,
// registered level plus one-cycle rise/fall pulses. Bit 0 brake, 1 ignition, 2 hidden.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input_debouncer_if.slave  dbif
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]            raw;
  logic [2:0]            ff1_d, ff1_q;
  logic [2:0]            ff2_d, ff2_q;
  logic [2:0]            out_d, out_q;
  logic [2:0]            rise_d, rise_q;
  logic [2:0]            fall_d, fall_q;
  logic [2:0][CNT_W-1:0] cnt_d, cnt_q;

  assign raw = {dbif.hidden_sw_raw, dbif.ignition_raw, dbif.break_raw};

  // ff2 is the synchronized level; any return of it to the accepted level
  // restarts the stability window.
  always_comb begin
    ff1_d  = raw;
    ff2_d  = ff1_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (ff2_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        out_d[i]  = ff2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = ff2_q[i];
        fall_d[i] = ~ff2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ff1_q  <= '0;
      ff2_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      ff1_q  <= ff1_d;
      ff2_q  <= ff2_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dbif.break_out = out_q[0];
  assign dbif.ignition  = out_q[1];
  assign dbif.hidden_sw = out_q[2];
  assign dbif.rise      = rise_q;
  assign dbif.fall      = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: each accepted transition is predicted
// when the raw level is driven and checked at the edge it must appear.
module tb_input_debouncer;

  localparam int D = 8;

  typedef struct {
    int         at_edge;
    logic [2:0] rise;
    logic [2:0] fall;
  } exp_t;

  logic clock;
  logic reset;
  int   edge_n;
  int   n_chk;
  int   n_fail;
  logic [2:0] mon_lvl;
  exp_t sb_q[$];

  input_debouncer_if dbif ();

  input_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .dbif  (dbif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raw level driven now is first sampled at the next edge k; acceptance at k+D+1.
  task automatic expect_accept(input logic [2:0] r, input logic [2:0] f);
    exp_t e;
    e.at_edge = edge_n + 1 + D + 1;
    e.rise    = r;
    e.fall    = f;
    sb_q.push_back(e);
  endtask

  task automatic set_raw(input logic [2:0] v);
    dbif.break_raw     = v[0];
    dbif.ignition_raw  = v[1];
    dbif.hidden_sw_raw = v[2];
  endtask

  function automatic logic [2:0] lvls();
    return {dbif.hidden_sw, dbif.ignition, dbif.break_out};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      mon_lvl = '0;
      chk("reset_hold", 32'({lvls(), dbif.rise, dbif.fall}), 32'd0);
    end else if (sb_q.size() > 0 && sb_q[0].at_edge == edge_n) begin
      e = sb_q.pop_front();
      chk("accept_pulse", 32'({dbif.rise, dbif.fall}), 32'({e.rise, e.fall}));
      mon_lvl = (mon_lvl | e.rise) & ~e.fall;
      chk("accept_level", 32'(lvls()), 32'(mon_lvl));
    end else begin
      chk("no_pulse", 32'({dbif.rise, dbif.fall}), 32'd0);
      chk("level_hold", 32'(lvls()), 32'(mon_lvl));
    end
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    mon_lvl = '0;
    reset   = 1'b0;
    set_raw(3'b000);
    tick(3);
    chk("reset_levels", 32'({lvls(), dbif.rise, dbif.fall}), 32'd0);
    reset = 1'b1;
    tick(4);

    // ignition rising, held
    set_raw(3'b010);
    expect_accept(3'b010, 3'b000);
    tick(14);

    // brake glitch one cycle short of the window: never accepted
    dbif.break_raw = 1'b1;
    tick(D - 1);
    dbif.break_raw = 1'b0;
    tick(14);
    chk("glitch_short_level", 32'(dbif.break_out), 32'd0);

    // brake pulse exactly the window long: accepted, then released
    dbif.break_raw = 1'b1;
    expect_accept(3'b001, 3'b000);
    tick(D);
    dbif.break_raw = 1'b0;
    expect_accept(3'b000, 3'b001);
    tick(14);

    // hidden switch bounces 1,0,1,0 in 3-cycle runs, then steady 1
    for (int p = 0; p < 4; p++) begin
      dbif.hidden_sw_raw = (p % 2 == 0);
      tick(3);
    end
    dbif.hidden_sw_raw = 1'b1;
    expect_accept(3'b100, 3'b000);
    tick(14);

    // bring everything low, then all channels together up and down
    set_raw(3'b000);
    expect_accept(3'b000, 3'b110);
    tick(14);
    set_raw(3'b111);
    expect_accept(3'b111, 3'b000);
    tick(14);
    set_raw(3'b000);
    expect_accept(3'b000, 3'b111);
    tick(14);

    // reset mid-window discards partial count
    dbif.ignition_raw = 1'b1;
    expect_accept(3'b010, 3'b000);
    tick(14);
    dbif.ignition_raw = 1'b0;
    tick(5);
    reset = 1'b0;
    #1;
    chk("async_reset_ign", 32'(dbif.ignition), 32'd0);
    chk("async_reset_pulses", 32'({dbif.rise, dbif.fall}), 32'd0);
    dbif.ignition_raw = 1'b1;
    tick(3);
    reset = 1'b1;
    expect_accept(3'b010, 3'b000);
    tick(14);

    // reset held while raw inputs toggle every cycle
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_raw((c % 2 == 0) ? 3'b111 : 3'b000);
      tick(1);
    end
    set_raw(3'b000);
    tick(2);
    reset = 1'b1;
    tick(12);

    for (int c = 0; c < 50 && sb_q.size() != 0; c++) tick(1);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 8, number of consecutive synchronized clock cycles a new level must hold before it is accepted; legal range 2..65535.
REQ-002 Parameter: CNT_W, default 16, width of each per-channel stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 break_raw  input  1  raw, asynchronous, bouncing brake-pedal switch.
REQ-006 ignition_raw  input  1  raw, asynchronous, bouncing ignition switch.
REQ-007 hidden_sw_raw  input  1  raw, asynchronous, bouncing hidden switch.
REQ-008 break  output  1  debounced brake level, drives fuel-pump stage break input.
REQ-009 ignition  output  1  debounced ignition level, drives fuel-pump stage ignition input.
REQ-010 hidden_sw  output  1  debounced hidden-switch level, drives fuel-pump stage hidden_sw input.
REQ-011 rise  output  3  one-cycle pulse per channel on accepted 0->1 transition; bit 0 break, bit 1 ignition, bit 2 hidden_sw.
REQ-012 fall  output  3  one-cycle pulse per channel on accepted 1->0 transition; same bit mapping as rise.

Function
REQ-013 Three identical, fully independent channels; no channel's state affects another.
REQ-014 Per channel: two-flop synchronizer (ff1 samples raw, ff2 samples ff1); ff2 is the synchronized level "sync".
REQ-015 Per channel: CNT_W-bit counter cnt and registered debounced level out (the break/ignition/hidden_sw output).
REQ-016 Each edge, sync == out: cnt <= 0, out unchanged.
REQ-017 Each edge, sync != out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, out unchanged.
REQ-018 Each edge, sync != out and cnt == DEBOUNCE_CYCLES-1: out <= sync, cnt <= 0.
REQ-019 Latency: raw level first sampled by ff1 at edge k and held stable thereafter -> out takes new level at edge k+DEBOUNCE_CYCLES+1.
REQ-020 Any sync mismatch run shorter than DEBOUNCE_CYCLES edges (glitch/bounce) returns cnt to 0 and never changes out.
REQ-021 Bounce restarts the window: each return of sync to out clears cnt; acceptance needs a fresh run of DEBOUNCE_CYCLES consecutive mismatch edges.
REQ-022 rise[i] registered, high for exactly the one cycle following the edge at which out[i] goes 0->1; fall[i] likewise for 1->0; never both high on one channel.
REQ-023 Consecutive accepted transitions on one channel are at least DEBOUNCE_CYCLES cycles apart; pulses never merge.
REQ-024 Multiple channels may accept transitions on the same edge; their rise/fall bits assert simultaneously.
REQ-025 cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around reachable.
REQ-026 Outputs purely registered; no combinational path from any raw input to any output.

Reset
REQ-027 reset low asynchronously forces all ff1, ff2, cnt to 0, break/ignition/hidden_sw to 0, rise/fall to 3'b000, independent of clock.
REQ-028 While reset low, outputs hold reset values regardless of raw inputs.
REQ-029 Reset asserted mid-window discards partial count; after release, debouncing restarts from out=0, cnt=0.
REQ-030 Raw input high through reset release: first post-release edge is edge k; out goes 1 at edge k+DEBOUNCE_CYCLES+1 with one rise pulse.

Verification
REQ-031 DEBOUNCE_CYCLES=8, ignition_raw 0->1 before edge k, held -> ignition=1 at edge k+9, rise[1]=1 exactly one cycle, fall=0.
REQ-032 break_raw high for 7 synchronized cycles then low -> break stays 0, rise[0] never asserts, cnt back to 0.
REQ-033 hidden_sw_raw bounces 1,0,1,0 each 3 cycles then steady 1 -> hidden_sw=1 exactly 9 edges after last steady 1 sampled by ff1; single rise[2] pulse.
REQ-034 All three raw inputs 0->1 same edge -> all outputs 1 on same edge, rise=3'b111 one cycle; later all 1->0 -> fall=3'b111 one cycle.
REQ-035 ignition accepted high, raw low for 5 cycles, reset pulsed low mid-window -> ignition=0 immediately, rise/fall=0; raw held high after release -> ignition=1 at edge 9 after release.
REQ-036 Reset held low with all raw inputs toggling every cycle -> all outputs remain 0 and rise/fall remain 3'b000 throughout.
